spi_frame_rx: RTL and testbench

Downstream SPI frame receiver that consumes the 64-bit (8-byte) bursts produced by the team's SPI master stage (mosi/mclk/cs). It sits in the receiving device's `clk` domain and oversamples the serial lines, which are asynchronous to `clk`. Received bytes are delivered through a small FIFO with a valid/ready handshake. The block also flags complete frames, truncated frames and FIFO overflow.

---
 rtl/spi_frame_rx.sv | 166 ++++++++++++++++
 tb/tb_spi_frame_rx.sv | 187 ++++++++++++++++++
 2 files changed

// File: rtl/spi_frame_rx.sv
// spi_frame_rx: oversampled SPI frame receiver with show-ahead byte FIFO; define SPI_RX_CHECKSUM_EN for XOR frame checksum
module spi_frame_rx #(
  parameter int FIFO_DEPTH  = 4,
  parameter int FRAME_BYTES = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       sclk,
  input  logic       cs_n,
  input  logic       mosi,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  input  logic       rx_ready,
  output logic       frame_done,
  output logic       frame_err,
  output logic       overflow,
  output logic       busy
);
  localparam int BITS = FRAME_BYTES * 8;
  localparam int CW   = $clog2(BITS);
  localparam int AW   = $clog2(FIFO_DEPTH);

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  state_t        r_state, w_next;
  logic [2:0]    r_sclk_sync, r_cs_sync, r_mosi_sync;
  logic [CW-1:0] r_bitcnt;
  logic [6:0]    r_shreg;
  logic [7:0]    r_mem [FIFO_DEPTH];
  logic [AW:0]   r_wptr, r_rptr;
  logic          r_frame_done, r_frame_err, r_overflow;
  logic          w_rise, w_cs_fall, w_cs_rise, w_last;
  logic          w_clear, w_shift, w_push, w_done, w_err;
  logic          w_full, w_empty, w_pop, w_wr;
  logic [7:0]    w_byte;
`ifdef SPI_RX_CHECKSUM_EN
  logic [7:0]    r_xor, w_xor_next;
`endif

  assign w_rise    = r_sclk_sync[1] & ~r_sclk_sync[2];
  assign w_cs_fall = ~r_cs_sync[1] & r_cs_sync[2];
  assign w_cs_rise = r_cs_sync[1] & ~r_cs_sync[2];
  assign w_last    = r_bitcnt == CW'(BITS - 1);
  assign w_byte    = {r_mosi_sync[1], r_shreg};
`ifdef SPI_RX_CHECKSUM_EN
  assign w_xor_next = r_xor ^ w_byte;
`endif

  assign w_empty  = r_wptr == r_rptr;
  assign w_full   = (r_wptr[AW] != r_rptr[AW]) && (r_wptr[AW-1:0] == r_rptr[AW-1:0]);
  assign rx_valid = ~w_empty;
  assign rx_data  = r_mem[r_rptr[AW-1:0]];
  assign w_pop    = rx_valid & rx_ready;
  assign w_wr     = w_push & (~w_full | w_pop);

  assign frame_done = r_frame_done;
  assign frame_err  = r_frame_err;
  assign overflow   = r_overflow;
  assign busy       = r_state != IDLE;

  // Three-flop synchronisers; index 0 is s1, 2 is s3, idle levels on reset
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_sclk_sync <= 3'b000;
      r_cs_sync   <= 3'b111;
      r_mosi_sync <= 3'b000;
    end else begin
      r_sclk_sync <= {r_sclk_sync[1:0], sclk};
      r_cs_sync   <= {r_cs_sync[1:0], cs_n};
      r_mosi_sync <= {r_mosi_sync[1:0], mosi};
    end
  end

  // FSM state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_next;
  end

  // Next state and per-cycle strobes; a frame-end bit decides done vs error
  always_comb begin
    w_next  = r_state;
    w_clear = 1'b0;
    w_shift = 1'b0;
    w_push  = 1'b0;
    w_done  = 1'b0;
    w_err   = 1'b0;
    case (r_state)
      IDLE: begin
        w_clear = w_cs_fall;
        w_next  = w_cs_fall ? SHIFT : IDLE;
      end
      SHIFT: begin
        if (w_cs_rise) begin
          w_err  = 1'b1;
          w_next = IDLE;
        end else if (w_rise && !r_cs_sync[1]) begin
          w_shift = 1'b1;
          w_push  = &r_bitcnt[2:0];
          if (w_last) begin
            w_next = DONE;
`ifdef SPI_RX_CHECKSUM_EN
            w_done = w_xor_next == 8'h00;
            w_err  = w_xor_next != 8'h00;
`else
            w_done = 1'b1;
`endif
          end
        end
      end
      DONE:    w_next = w_cs_rise ? IDLE : DONE;
      default: w_next = IDLE;
    endcase
  end

  // Bit counter and partial byte; bit 7 is taken straight from mosi when the byte completes
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_bitcnt <= '0;
      r_shreg  <= '0;
    end else if (w_clear) begin
      r_bitcnt <= '0;
      r_shreg  <= '0;
    end else if (w_shift) begin
      r_bitcnt <= r_bitcnt + 1'b1;
      if (!(&r_bitcnt[2:0])) r_shreg[r_bitcnt[2:0]] <= r_mosi_sync[1];
    end
  end

`ifdef SPI_RX_CHECKSUM_EN
  // Running XOR over every completed byte of the frame
  always_ff @(posedge clk or posedge rst) begin
    if (rst)         r_xor <= '0;
    else if (w_clear) r_xor <= '0;
    else if (w_push)  r_xor <= w_xor_next;
  end
`endif

  // Registered one-cycle status pulses
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_frame_done <= 1'b0;
      r_frame_err  <= 1'b0;
      r_overflow   <= 1'b0;
    end else begin
      r_frame_done <= w_done;
      r_frame_err  <= w_err;
      r_overflow   <= w_push & w_full & ~w_pop;
    end
  end

  // Byte FIFO; a pop on the same cycle frees the slot for a push into a full FIFO
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wptr <= '0;
      r_rptr <= '0;
      for (int i = 0; i < FIFO_DEPTH; i++) r_mem[i] <= '0;
    end else begin
      if (w_wr) begin
        r_mem[r_wptr[AW-1:0]] <= w_byte;
        r_wptr <= r_wptr + 1'b1;
      end
      if (w_pop) r_rptr <= r_rptr + 1'b1;
    end
  end
endmodule

// File: tb/tb_spi_frame_rx.sv
// tb_spi_frame_rx: table-driven frames plus hand sequences, scoreboard of expected bytes
module tb_spi_frame_rx;
  localparam int DEPTH = 4;
`ifdef SPI_RX_CHECKSUM_EN
  localparam bit CK = 1'b1;
`else
  localparam bit CK = 1'b0;
`endif

  logic clk = 0, rst = 1, sclk = 0, cs_n = 1, mosi = 0, rx_ready = 0;
  logic [7:0] rx_data;
  logic rx_valid, frame_done, frame_err, overflow, busy;

  always #5 clk = ~clk;

  spi_frame_rx #(.FIFO_DEPTH(DEPTH), .FRAME_BYTES(8)) dut (
    .clk(clk), .rst(rst), .sclk(sclk), .cs_n(cs_n), .mosi(mosi),
    .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready),
    .frame_done(frame_done), .frame_err(frame_err), .overflow(overflow), .busy(busy)
  );

  int checks = 0, errors = 0;
  int n_done = 0, n_err = 0, n_ovf = 0, exp_ovf = 0;
  logic [7:0] q[$];

  typedef struct packed {
    logic [63:0] d;
    logic [7:0]  nbits;
    logic [1:0]  e_done;
    logic [1:0]  e_err;
  } vec_t;
  vec_t v [5];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic model_push(input logic [7:0] b, input logic pulse);
    if (!rx_ready && !pulse && q.size() >= DEPTH) exp_ovf++;
    else q.push_back(b);
  endtask

  task automatic send_bit(input logic b, input logic pe, input logic [7:0] byt, input logic pulse);
    mosi = b;
    tick(4);
    if (pe) model_push(byt, pulse);
    sclk = 1;
    if (pulse) begin
      tick(2);
      rx_ready = 1;
      tick(1);
      rx_ready = 0;
      tick(1);
    end else tick(4);
    sclk = 0;
  endtask

  task automatic send_frame(input logic [63:0] d, input int nbits, input int extra, input int pulse_byte);
    cs_n = 0;
    tick(4);
    for (int i = 0; i < nbits; i++)
      send_bit(d[i], i % 8 == 7, d[8*(i/8) +: 8], (i / 8 == pulse_byte) && (i % 8 == 7));
    for (int i = 0; i < extra; i++) send_bit(1'b1, 1'b0, 8'h00, 1'b0);
    tick(4);
    cs_n = 1;
    tick(8);
  endtask

  always @(negedge clk) begin
    if (!rst) begin
      if (rx_valid && rx_ready) begin
        if (q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_byte: got %0h expected none", rx_data);
        end else chk("rx_data", rx_data, q.pop_front());
      end
      n_done += int'(frame_done);
      n_err  += int'(frame_err);
      n_ovf  += int'(overflow);
    end
  end

  initial begin
    #2ms;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1);
  end

  initial begin
    int d0, e0, o0, eo0;
    v[0] = '{d: 64'h0807060504030201, nbits: 8'd64, e_done: CK ? 2'd0 : 2'd1, e_err: CK ? 2'd1 : 2'd0};
    v[1] = '{d: 64'h00000000005A3CA5, nbits: 8'd20, e_done: 2'd0, e_err: 2'd1};
    v[2] = '{d: 64'h1817161514131211, nbits: 8'd64, e_done: CK ? 2'd0 : 2'd1, e_err: CK ? 2'd1 : 2'd0};
    v[3] = '{d: 64'h0007060504030201, nbits: 8'd64, e_done: 2'd1, e_err: 2'd0};
    v[4] = '{d: 64'h0907060504030201, nbits: 8'd64, e_done: CK ? 2'd0 : 2'd1, e_err: CK ? 2'd1 : 2'd0};

    tick(3);
    chk("reset_rx_data", rx_data, 8'h00);
    chk("reset_rx_valid", rx_valid, 0);
    chk("reset_frame_done", frame_done, 0);
    chk("reset_frame_err", frame_err, 0);
    chk("reset_overflow", overflow, 0);
    chk("reset_busy", busy, 0);
    rst = 0;
    tick(4);

    rx_ready = 1;
    for (int i = 0; i < 5; i++) begin
      d0 = n_done; e0 = n_err; o0 = n_ovf;
      send_frame(v[i].d, int'(v[i].nbits), 0, -1);
      tick(4);
      chk($sformatf("v%0d_done", i), n_done - d0, 32'(v[i].e_done));
      chk($sformatf("v%0d_err", i), n_err - e0, 32'(v[i].e_err));
      chk($sformatf("v%0d_ovf", i), n_ovf - o0, 0);
      chk($sformatf("v%0d_pending", i), q.size(), 0);
      chk($sformatf("v%0d_rx_valid", i), rx_valid, 0);
      chk($sformatf("v%0d_busy", i), busy, 0);
    end

    rx_ready = 0;
    d0 = n_done; o0 = n_ovf; eo0 = exp_ovf;
    send_frame(64'h1716151413121110, 64, 0, -1);
    chk("ovf_pulses", n_ovf - o0, 4);
    chk("ovf_model", n_ovf - o0, exp_ovf - eo0);
    chk("ovf_done", n_done - d0, 1);
    chk("ovf_occupancy", q.size(), DEPTH);
    chk("ovf_head", rx_data, 8'h10);

    e0 = n_err; o0 = n_ovf;
    send_frame(64'h0000000000000099, 8, 0, 0);
    chk("simul_no_ovf", n_ovf - o0, 0);
    chk("simul_err", n_err - e0, 1);
    chk("simul_occupancy", q.size(), DEPTH);
    chk("simul_head", rx_data, 8'h11);
    chk("simul_valid", rx_valid, 1);
    rx_ready = 1;
    for (int i = 0; i < 40 && q.size() != 0; i++) tick(1);
    chk("drain_pending", q.size(), 0);
    tick(2);
    chk("drain_rx_valid", rx_valid, 0);

    cs_n = 0;
    tick(4);
    for (int i = 0; i < 30; i++) begin
      logic [63:0] dd;
      dd = 64'h2827262524232221;
      send_bit(dd[i], i % 8 == 7, dd[8*(i/8) +: 8], 1'b0);
    end
    rst = 1;
    tick(2);
    chk("midrst_rx_data", rx_data, 8'h00);
    chk("midrst_rx_valid", rx_valid, 0);
    chk("midrst_busy", busy, 0);
    chk("midrst_frame_done", frame_done, 0);
    chk("midrst_frame_err", frame_err, 0);
    chk("midrst_overflow", overflow, 0);
    q.delete();
    cs_n = 1;
    sclk = 0;
    tick(3);
    rst = 0;
    tick(4);
    chk("postrst_busy", busy, 0);

    d0 = n_done; e0 = n_err; o0 = n_ovf;
    send_frame(64'h1817161514131211, 64, 5, -1);
    tick(4);
    chk("trail_done", n_done - d0, CK ? 0 : 1);
    chk("trail_err", n_err - e0, CK ? 1 : 0);
    chk("trail_ovf", n_ovf - o0, 0);
    chk("trail_pending", q.size(), 0);
    chk("trail_rx_valid", rx_valid, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
